// File: rtl/fp_alu_sched.sv
// fp_alu_sched: shares one fp_alu between NREQ requesters.
//
// A round-robin arbiter grants one request at a time through a valid/ready
// handshake. The granted operands and op code are registered onto the ALU
// inputs and held for the op-dependent ALU latency. The ALU result is then
// captured and returned with the requester index on a valid/ready response
// channel. Only one op is in flight at a time.
//
// Ports:
//   clk, rstn             clock, asynchronous active-low reset
//   req_valid/req_ready   per-requester request handshake (ready one-hot or zero)
//   req_num1/req_num2     packed 32-bit operands, requester i at [32i+31:32i]
//   req_op                packed 2-bit op codes (00 add, 01 sub, 10 mul, 11 div)
//   rsp_valid/rsp_ready   response handshake
//   rsp_data/rsp_id       result word and index of the issuing requester
//   alu_num1/2, alu_op    registered drive to the shared fp_alu
//   alu_s                 fp_alu result
//   busy                  an op is being executed or returned
module fp_alu_sched #(
   parameter int unsigned NREQ       = 2,
   parameter int unsigned LAT_ADDSUB = 3,
   parameter int unsigned LAT_MUL    = 3,
   parameter int unsigned LAT_DIV    = 4,
   parameter int unsigned IDW        = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [NREQ*32-1:0]   req_num1,
   input  logic [NREQ*32-1:0]   req_num2,
   input  logic [NREQ*2-1:0]    req_op,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [31:0]          rsp_data,
   output logic [IDW-1:0]       rsp_id,
   output logic [31:0]          alu_num1,
   output logic [31:0]          alu_num2,
   output logic [1:0]           alu_op,
   input  logic [31:0]          alu_s,
   output logic                 busy
);

   localparam int unsigned LAT_MAX =
      (LAT_ADDSUB > LAT_MUL) ? ((LAT_ADDSUB > LAT_DIV) ? LAT_ADDSUB : LAT_DIV)
                             : ((LAT_MUL > LAT_DIV) ? LAT_MUL : LAT_DIV);
   localparam int unsigned CNTW = $clog2(LAT_MAX + 1);

   typedef enum logic [1:0] {
      StIdle,
      StExec,
      StResp
   } state_e;

   state_e            state_q, state_d;
   logic [CNTW-1:0]   cnt_q, cnt_d;
   logic [IDW-1:0]    rr_q, rr_d;
   logic [31:0]       num1_q, num1_d;
   logic [31:0]       num2_q, num2_d;
   logic [1:0]        op_q, op_d;
   logic [31:0]       data_q, data_d;
   logic [IDW-1:0]    id_q, id_d;

   logic              gnt_found;
   logic [IDW-1:0]    gnt_idx;
   int unsigned       scan_idx;
   logic [31:0]       sel_num1, sel_num2;
   logic [1:0]        sel_op;

   function automatic logic [CNTW-1:0] lat_of(input logic [1:0] op);
      logic [CNTW-1:0] lat;
      unique case (op)
         2'b10:   lat = CNTW'(LAT_MUL);
         2'b11:   lat = CNTW'(LAT_DIV);
         default: lat = CNTW'(LAT_ADDSUB);
      endcase
      return lat;
   endfunction

   // Round-robin search: first asserted valid at or after rr_q, wrapping.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      scan_idx  = 0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         scan_idx = 32'(rr_q) + i;
         if (scan_idx >= NREQ) begin
            scan_idx = scan_idx - NREQ;
         end
         if (!gnt_found && req_valid[scan_idx[IDW-1:0]]) begin
            gnt_found = 1'b1;
            gnt_idx   = scan_idx[IDW-1:0];
         end
      end
   end

   // Operand mux for the winning requester.
   always_comb begin
      sel_num1 = '0;
      sel_num2 = '0;
      sel_op   = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (32'(gnt_idx) == i) begin
            sel_num1 = req_num1[32*i +: 32];
            sel_num2 = req_num2[32*i +: 32];
            sel_op   = req_op[2*i +: 2];
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (state_q == StIdle && gnt_found) begin
         req_ready[gnt_idx] = 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rr_d    = rr_q;
      num1_d  = num1_q;
      num2_d  = num2_q;
      op_d    = op_q;
      data_d  = data_q;
      id_d    = id_q;
      unique case (state_q)
         StIdle: begin
            if (gnt_found) begin
               num1_d  = sel_num1;
               num2_d  = sel_num2;
               op_d    = sel_op;
               id_d    = gnt_idx;
               cnt_d   = lat_of(sel_op);
               rr_d    = (32'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;
               state_d = StExec;
            end
         end
         StExec: begin
            cnt_d = cnt_q - 1'b1;
            // Last exec cycle: alu_s has been stable for the full latency.
            if (cnt_q == CNTW'(1)) begin
               data_d  = alu_s;
               state_d = StResp;
            end
         end
         StResp: begin
            if (rsp_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         rr_q    <= '0;
         num1_q  <= '0;
         num2_q  <= '0;
         op_q    <= '0;
         data_q  <= '0;
         id_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rr_q    <= rr_d;
         num1_q  <= num1_d;
         num2_q  <= num2_d;
         op_q    <= op_d;
         data_q  <= data_d;
         id_q    <= id_d;
      end
   end

   assign rsp_valid = (state_q == StResp);
   assign busy      = (state_q != StIdle);
   assign rsp_data  = data_q;
   assign rsp_id    = id_q;
   assign alu_num1  = num1_q;
   assign alu_num2  = num2_q;
   assign alu_op    = op_q;

endmodule

// File: tb/tb_fp_alu_sched.sv
// Testbench for fp_alu_sched. Acts as the shared fp_alu: alu_s carries the
// correct result only once the ALU inputs have been stable for the op latency,
// and a poison word before that.
module tb_fp_alu_sched;

   localparam int unsigned NREQ       = 2;
   localparam int unsigned LAT_ADDSUB = 3;
   localparam int unsigned LAT_MUL    = 3;
   localparam int unsigned LAT_DIV    = 4;
   localparam int unsigned IDW        = 1;
   localparam int          VMAX       = (1 << NREQ) - 1;

   logic                clk = 1'b0;
   logic                rstn;
   logic [NREQ-1:0]     req_valid;
   logic [NREQ-1:0]     req_ready;
   logic [NREQ*32-1:0]  req_num1;
   logic [NREQ*32-1:0]  req_num2;
   logic [NREQ*2-1:0]   req_op;
   logic                rsp_valid;
   logic                rsp_ready;
   logic [31:0]         rsp_data;
   logic [IDW-1:0]      rsp_id;
   logic [31:0]         alu_num1;
   logic [31:0]         alu_num2;
   logic [1:0]          alu_op;
   logic [31:0]         alu_s;
   logic                busy;

   int checks = 0;
   int errors = 0;
   int rr_m   = 0;

   fp_alu_sched #(
      .NREQ       (NREQ),
      .LAT_ADDSUB (LAT_ADDSUB),
      .LAT_MUL    (LAT_MUL),
      .LAT_DIV    (LAT_DIV),
      .IDW        (IDW)
   ) dut (
      .clk       (clk),
      .rstn      (rstn),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_num1  (req_num1),
      .req_num2  (req_num2),
      .req_op    (req_op),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_id    (rsp_id),
      .alu_num1  (alu_num1),
      .alu_num2  (alu_num2),
      .alu_op    (alu_op),
      .alu_s     (alu_s),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   function automatic int lat_of(input logic [1:0] op);
      case (op)
         2'b10:   return int'(LAT_MUL);
         2'b11:   return int'(LAT_DIV);
         default: return int'(LAT_ADDSUB);
      endcase
   endfunction

   // ALU stand-in: exact IEEE results for the directed cases, an arbitrary
   // deterministic mix otherwise (the scheduler only passes the word through).
   function automatic logic [31:0] fref(input logic [31:0] a, input logic [31:0] b,
                                        input logic [1:0] op);
      if (op == 2'b00 && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
      if (op == 2'b01 && a == 32'h40400000 && b == 32'h3F800000) return 32'h40000000;
      if (op == 2'b10 && a == 32'h40000000 && b == 32'h40400000) return 32'h40C00000;
      if (op == 2'b11 && a == 32'h40C00000 && b == 32'h40000000) return 32'h40400000;
      return (a ^ {b[15:0], b[31:16]}) + {30'd0, op};
   endfunction

   // Stability tracking of the ALU inputs.
   logic [31:0] p_n1 = '0;
   logic [31:0] p_n2 = '0;
   logic [1:0]  p_op = '0;
   int          age  = 1;
   int          cur_age;

   assign cur_age = (alu_num1 === p_n1 && alu_num2 === p_n2 && alu_op === p_op) ? age + 1 : 1;
   assign alu_s   = (cur_age >= lat_of(alu_op)) ? fref(alu_num1, alu_num2, alu_op)
                                                : 32'hDEADBEEF;

   always @(posedge clk) begin
      age  <= cur_age;
      p_n1 <= alu_num1;
      p_n2 <= alu_num2;
      p_op <= alu_op;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int pick(input logic [NREQ-1:0] vld);
      for (int i = 0; i < int'(NREQ); i++) begin
         if (vld[(rr_m + i) % int'(NREQ)]) return (rr_m + i) % int'(NREQ);
      end
      return -1;
   endfunction

   // One complete transaction: grant, exec cycles, response with bp stall cycles.
   task automatic run_op(input logic [NREQ-1:0] vld, input int bp, input bit wiggle);
      int              g;
      int              lat;
      logic [31:0]     a;
      logic [31:0]     b;
      logic [31:0]     exp_s;
      logic [1:0]      op;
      logic [NREQ-1:0] oh;
      g     = pick(vld);
      a     = req_num1[32*g +: 32];
      b     = req_num2[32*g +: 32];
      op    = req_op[2*g +: 2];
      lat   = lat_of(op);
      exp_s = fref(a, b, op);
      oh    = '0;
      oh[g] = 1'b1;
      @(negedge clk);
      req_valid = vld;
      rsp_ready = (bp == 0);
      #1;
      chk("idle_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("idle_busy", 64'(busy), 64'd0);
      chk("grant", 64'(req_ready), 64'(oh));
      rr_m = (g + 1) % int'(NREQ);
      for (int k = 1; k <= lat; k++) begin
         @(negedge clk);
         if (wiggle) begin
            req_op[1:0]    = req_op[1:0] + 2'd1;
            req_num1[31:0] = $urandom;
         end
         #1;
         chk("exec_ready", 64'(req_ready), 64'd0);
         chk("exec_rsp_valid", 64'(rsp_valid), 64'd0);
         chk("exec_busy", 64'(busy), 64'd1);
         chk("exec_alu_op", 64'(alu_op), 64'(op));
         chk("exec_alu_num1", 64'(alu_num1), 64'(a));
         chk("exec_alu_num2", 64'(alu_num2), 64'(b));
      end
      for (int i = 0; i <= bp; i++) begin
         @(negedge clk);
         rsp_ready = (i == bp);
         if (wiggle) begin
            req_op[1:0] = req_op[1:0] + 2'd1;
         end
         #1;
         chk("resp_valid", 64'(rsp_valid), 64'd1);
         chk("resp_data", 64'(rsp_data), 64'(exp_s));
         chk("resp_id", 64'(rsp_id), 64'(g));
         chk("resp_ready", 64'(req_ready), 64'd0);
         chk("resp_alu_op", 64'(alu_op), 64'(op));
         chk("resp_alu_num1", 64'(alu_num1), 64'(a));
      end
   endtask

   task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] op);
      req_num1[32*i +: 32] = a;
      req_num2[32*i +: 32] = b;
      req_op[2*i +: 2]     = op;
   endtask

   initial begin
      logic [NREQ-1:0] vld;
      rstn      = 1'b0;
      req_valid = '0;
      rsp_ready = 1'b0;
      req_num1  = '0;
      req_num2  = '0;
      req_op    = '0;
      #12;
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_rsp_data", 64'(rsp_data), 64'd0);
      chk("rst_rsp_id", 64'(rsp_id), 64'd0);
      chk("rst_alu_num1", 64'(alu_num1), 64'd0);
      chk("rst_alu_num2", 64'(alu_num2), 64'd0);
      chk("rst_alu_op", 64'(alu_op), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      @(negedge clk);
      rstn = 1'b1;

      // Single add from requester 0.
      set_req(0, 32'h3F800000, 32'h40000000, 2'b00);
      run_op(2'b01, 0, 1'b0);

      // Div and mul latencies from requester 1.
      set_req(1, 32'h40C00000, 32'h40000000, 2'b11);
      run_op(2'b10, 0, 1'b0);
      set_req(1, 32'h40000000, 32'h40400000, 2'b10);
      run_op(2'b10, 0, 1'b0);

      // Contention: both valid continuously, grants alternate from 0.
      set_req(0, 32'h40400000, 32'h3F800000, 2'b01);
      for (int n = 0; n < 4; n++) begin
         run_op(2'b11, 0, 1'b0);
      end

      // Backpressure: ten stalled response cycles.
      run_op(2'b11, 10, 1'b0);

      // Op code on the request port changes throughout exec and response.
      set_req(0, 32'h3F800000, 32'h40000000, 2'b00);
      run_op(2'b01, 2, 1'b1);

      // Reset two cycles after a div is accepted.
      set_req(0, 32'h40C00000, 32'h40000000, 2'b11);
      rr_m = 0;
      @(negedge clk);
      req_valid = 2'b01;
      rsp_ready = 1'b0;
      #1;
      chk("rst_test_grant", 64'(req_ready), 64'd1);
      @(negedge clk);
      #1;
      chk("rst_test_busy", 64'(busy), 64'd1);
      @(negedge clk);
      rstn      = 1'b0;
      req_valid = '0;
      #1;
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("midrst_alu_op", 64'(alu_op), 64'd0);
      chk("midrst_alu_num1", 64'(alu_num1), 64'd0);
      chk("midrst_alu_num2", 64'(alu_num2), 64'd0);
      chk("midrst_rsp_id", 64'(rsp_id), 64'd0);
      chk("midrst_rsp_data", 64'(rsp_data), 64'd0);
      @(negedge clk);
      rstn = 1'b1;
      for (int n = 0; n < 6; n++) begin
         @(negedge clk);
         #1;
         chk("post_rst_no_rsp", 64'(rsp_valid), 64'd0);
         chk("post_rst_idle", 64'(busy), 64'd0);
      end
      rr_m = 0;
      set_req(1, 32'h40000000, 32'h40400000, 2'b10);
      run_op(2'b11, 0, 1'b0);

      // Randomized traffic.
      for (int n = 0; n < 60; n++) begin
         for (int i = 0; i < int'(NREQ); i++) begin
            set_req(i, $urandom, $urandom, 2'($urandom));
            if ($urandom_range(0, 4) == 0) req_num1[32*i +: 32] = 32'h7FC00000;
            if ($urandom_range(0, 4) == 0) req_num2[32*i +: 32] = 32'h7F800000;
         end
         if ($urandom_range(0, 3) == 0) begin
            @(negedge clk);
            req_valid = '0;
            #1;
            chk("rand_idle_ready", 64'(req_ready), 64'd0);
            chk("rand_idle_busy", 64'(busy), 64'd0);
         end
         vld = NREQ'($urandom_range(1, VMAX));
         run_op(vld, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      end

      @(negedge clk);
      req_valid = '0;
      #1;
      chk("final_idle", 64'(busy), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
